win_detector: RTL and testbench

Parametrised, debounced win detector for the puzzle-board datapath. Watches the board state vector and declares a win only after a winning pattern has been stable for a programmable number of cycles. On a win it latches which pattern matched, drives a timed buzzer pulse, and counts wins. It re-arms only after an explicit clear followed by the board leaving every winning pattern.

---
 rtl/win_detector.sv | 167 ++++++++++++++++
 tb/tb_win_detector.sv | 113 +++++++++++
 2 files changed

// File: rtl/win_detector.sv
// Debounced win detector: qualifies a stable winning board pattern, latches its id,
// pulses the buzzer and counts wins. Optional macro WIN_DETECTOR_ALT_PATTERNS_EN adds altA/altB.
module win_detector #(
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int BUZZ_CYCLES = 1000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] screen,
  input  logic             clear,
  output logic             win,
  output logic             buzz,
  output logic [1:0]       match_id,
  output logic [CNT_W-1:0] win_count
);

  localparam int CNT_BITS  = $clog2(HOLD_CYCLES + 1);
  localparam int BUZZ_BITS = $clog2(BUZZ_CYCLES + 1);

  localparam logic [CNT_BITS-1:0]  HOLD_VAL  = CNT_BITS'(HOLD_CYCLES);
  localparam logic [BUZZ_BITS-1:0] BUZZ_VAL  = BUZZ_BITS'(BUZZ_CYCLES);
  localparam logic [CNT_W-1:0]     COUNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_WIN     = 2'd2;
  localparam logic [1:0] ST_REARM   = 2'd3;

  // Returns {valid, id}; the patterns are mutually exclusive so priority order is irrelevant.
  function automatic logic [2:0] decode_pattern(input logic [WIDTH-1:0] s);
    logic [2:0] r;
`ifdef WIN_DETECTOR_ALT_PATTERNS_EN
    logic [WIDTH-1:0] alt_a;
    logic [WIDTH-1:0] alt_b;
    for (int i = 0; i < WIDTH; i++) begin
      alt_a[i] = ((i % 2) == 0);
      alt_b[i] = ((i % 2) != 0);
    end
`endif
    if (s == {WIDTH{1'b0}}) begin
      r = 3'b100;
    end else if (s == {WIDTH{1'b1}}) begin
      r = 3'b101;
`ifdef WIN_DETECTOR_ALT_PATTERNS_EN
    end else if (s == alt_a) begin
      r = 3'b110;
    end else if (s == alt_b) begin
      r = 3'b111;
`endif
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  logic [WIDTH-1:0]     screen_r;
  logic [2:0]           decode_s;
  logic                 pat_valid_s;
  logic [1:0]           pat_id_s;
  logic [1:0]           state_r, state_s;
  logic [CNT_BITS-1:0]  cnt_r, cnt_s;
  logic [1:0]           cand_r, cand_s;
  logic [BUZZ_BITS-1:0] buzz_cnt_r, buzz_cnt_s;
  logic [1:0]           match_id_r, match_id_s;
  logic [CNT_W-1:0]     win_count_r, win_count_s;
  logic                 win_r, buzz_r;

  // Board sample register; deliberately not reset so it always reflects the live board.
  always_ff @(posedge clk) begin
    screen_r <= screen;
  end

  assign decode_s    = decode_pattern(screen_r);
  assign pat_valid_s = decode_s[2];
  assign pat_id_s    = decode_s[1:0];

  // Next-state and datapath update for the qualify/win/re-arm sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cand_s      = cand_r;
    buzz_cnt_s  = buzz_cnt_r;
    match_id_s  = match_id_r;
    win_count_s = win_count_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && pat_valid_s) begin
          cand_s  = pat_id_s;
          cnt_s   = CNT_BITS'(1);
          state_s = ST_QUALIFY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_QUALIFY: begin
        if (!enable || !pat_valid_s || (pat_id_s != cand_r)) begin
          state_s = ST_IDLE;
        end else if (cnt_r == HOLD_VAL) begin
          state_s    = ST_WIN;
          match_id_s = cand_r;
          buzz_cnt_s = BUZZ_VAL;
          if (win_count_r != COUNT_MAX) begin
            win_count_s = win_count_r + CNT_W'(1);
          end else begin
            win_count_s = win_count_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_BITS'(1);
        end
      end
      ST_WIN: begin
        if (buzz_cnt_r != {BUZZ_BITS{1'b0}}) begin
          buzz_cnt_s = buzz_cnt_r - BUZZ_BITS'(1);
        end else begin
          buzz_cnt_s = buzz_cnt_r;
        end
        if (clear) begin
          state_s = ST_REARM;
        end else begin
          state_s = ST_WIN;
        end
      end
      ST_REARM: begin
        if (!pat_valid_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REARM;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State registers; win/buzz are registered from next-state so they change on the deciding edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_BITS{1'b0}};
      cand_r      <= 2'd0;
      buzz_cnt_r  <= {BUZZ_BITS{1'b0}};
      match_id_r  <= 2'd0;
      win_count_r <= {CNT_W{1'b0}};
      win_r       <= 1'b0;
      buzz_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cand_r      <= cand_s;
      buzz_cnt_r  <= buzz_cnt_s;
      match_id_r  <= match_id_s;
      win_count_r <= win_count_s;
      win_r       <= (state_s == ST_WIN);
      buzz_r      <= (state_s == ST_WIN) && (buzz_cnt_s != {BUZZ_BITS{1'b0}});
    end
  end

  assign win       = win_r;
  assign buzz      = buzz_r;
  assign match_id  = match_id_r;
  assign win_count = win_count_r;

endmodule

// File: tb/tb_win_detector.sv
// Directed scoreboard bench for win_detector (WIDTH=8, HOLD=4, BUZZ=10, CNT_W=2).
module tb_win_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] screen;
  logic       clear;
  logic       win;
  logic       buzz;
  logic [1:0] match_id;
  logic [1:0] win_count;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [1:0] alt_id;
  logic       alt_win;

  win_detector #(.WIDTH(8), .HOLD_CYCLES(4), .BUZZ_CYCLES(10), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .screen(screen), .clear(clear),
    .win(win), .buzz(buzz), .match_id(match_id), .win_count(win_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input logic w, input logic b, input logic [1:0] id,
                                    input logic [1:0] c);
    return {w, b, id, c};
  endfunction

  // Drive one cycle of inputs, queue the expected outputs after the edge, then compare.
  task automatic step(input string tag, input logic [7:0] scr, input logic en, input logic clr,
                      input logic rst, input logic [5:0] e);
    logic [5:0] want;
    logic [5:0] got;
    screen = scr; enable = en; clear = clr; reset = rst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = {win, buzz, match_id, win_count};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed win/buzz/id/cnt=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [7:0] scr, input logic en,
                     input logic clr, input logic rst, input logic [5:0] e);
    for (int i = 0; i < n; i++) step(tag, scr, en, clr, rst, e);
  endtask

  initial begin
`ifdef WIN_DETECTOR_ALT_PATTERNS_EN
    alt_win = 1'b1; alt_id = 2'd3;
`else
    alt_win = 1'b0; alt_id = 2'd1;
`endif
    screen = 8'h3C; enable = 1'b1; clear = 1'b0; reset = 1'b1;

    run("reset",        2, 8'h3C, 1'b1, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd0, 2'd0));
    // First win on all-zero: win at the 6th sample edge, buzz for 10 cycles.
    run("zero_qual",    5, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd0));
    run("zero_buzz",   10, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b1, 2'd0, 2'd1));
    run("zero_quiet",   3, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b0, 2'd0, 2'd1));
    run("zero_clear",   1, 8'h00, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("rearm_hold",   6, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("rearm_exit",   3, 8'h3C, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));

    run("alt55_short",  3, 8'h55, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("break_12",     8, 8'h12, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("clear_idle",   1, 8'h12, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));

    // All-one with enable dropped mid-qualify: qualification restarts, win 3 edges later.
    run("ff_pre",       3, 8'hFF, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("ff_en_low",    1, 8'hFF, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("ff_restart",   4, 8'hFF, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd1));
    run("ff_win",       2, 8'hFF, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b1, 2'd1, 2'd2));
    run("clear_buzz3",  1, 8'hFF, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd2));
    run("ff_no_rewin",  8, 8'hFF, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd2));
    run("ff_gap",       1, 8'h3C, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd2));
    run("ff_requal",    5, 8'hFF, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd2));
    run("ff_rewin",     1, 8'hFF, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b1, 2'd1, 2'd3));
    run("ff_clear",     1, 8'hFF, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd3));
    run("ff_exit",      2, 8'h3C, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd3));

    // altB (8'hAA) only wins when the alternate patterns are built in.
    run("aa_qual",      5, 8'hAA, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd1, 2'd3));
    run("aa_buzz",     10, 8'hAA, 1'b1, 1'b0, 1'b0, ex(alt_win, alt_win, alt_id, 2'd3));
    run("aa_tail",      5, 8'hAA, 1'b1, 1'b0, 1'b0, ex(alt_win, 1'b0, alt_id, 2'd3));
    run("aa_clear",     1, 8'hAA, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, alt_id, 2'd3));
    run("aa_exit",      2, 8'h3C, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, alt_id, 2'd3));

    // Further win with the counter already saturated.
    run("sat_qual",     5, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, alt_id, 2'd3));
    run("sat_win",      2, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b1, 2'd0, 2'd3));
    run("sat_clear",    1, 8'h00, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd3));
    run("sat_exit",     2, 8'h3C, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd3));

    // Reset mid-qualify, then a full-latency win proves state and counters cleared.
    run("mid_qual",     3, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd3));
    run("mid_reset",    1, 8'h00, 1'b1, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd0, 2'd0));
    run("post_reset",   4, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 2'd0, 2'd0));
    run("post_win",     1, 8'h00, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b1, 2'd0, 2'd1));
    run("buzz_reset",   1, 8'h00, 1'b1, 1'b0, 1'b1, ex(1'b0, 1'b0, 2'd0, 2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
